// File: rtl/pulse_width_sweeper.sv
// Sweeps a pulse-tone pulse_width between programmable bounds, stepping on the sample strobe.
// Optional triangle looping is compiled in with `define PULSE_SWEEP_LOOP_EN.
module pulse_width_sweeper #(
  parameter int PULSEWIDTH_BITS = 12,
  parameter int RATE_BITS       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_tick,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [PULSEWIDTH_BITS-1:0] cfg_min,
  input  logic [PULSEWIDTH_BITS-1:0] cfg_max,
  input  logic [PULSEWIDTH_BITS-1:0] cfg_step,
  input  logic [RATE_BITS-1:0]       cfg_rate,
  input  logic                       cfg_loop,
  input  logic                       start,
  input  logic                       stop,
  output logic [PULSEWIDTH_BITS-1:0] pulse_width,
  output logic                       busy,
  output logic                       done
);
  localparam int W = PULSEWIDTH_BITS;

  typedef enum logic [1:0] {IDLE, UP, DOWN, HOLD} state_t;

  state_t         state, state_n;
  logic [W-1:0]   pw_n, min_q, min_n, max_q, max_n, step_q, step_n;
  logic [RATE_BITS-1:0] presc, presc_n, rate_q, rate_n;
  logic           busy_n, done_n, ready_n, cfg_xfer, loop_eff;
  logic [W:0]     up_sum, dn_diff;

`ifdef PULSE_SWEEP_LOOP_EN
  logic loop_q, loop_n;
  assign loop_eff = loop_q;
`else
  logic unused_cfg_loop;
  assign unused_cfg_loop = cfg_loop;
  assign loop_eff        = 1'b0;
`endif

  // One extra bit so saturation and borrow are detected instead of wrapping.
  assign up_sum  = {1'b0, pulse_width} + {1'b0, step_q};
  assign dn_diff = {1'b0, pulse_width} - {1'b0, step_q};
  assign cfg_xfer = cfg_valid && cfg_ready;

  always_comb begin
    state_n = state;
    pw_n    = pulse_width;
    presc_n = presc;
    min_n   = min_q;
    max_n   = max_q;
    step_n  = step_q;
    rate_n  = rate_q;
    done_n  = 1'b0;
`ifdef PULSE_SWEEP_LOOP_EN
    loop_n  = loop_q;
`endif
    if (cfg_xfer) begin
      min_n  = cfg_min;
      max_n  = (cfg_min > cfg_max) ? cfg_min : cfg_max;
      step_n = (cfg_step == '0) ? {{(W-1){1'b0}}, 1'b1} : cfg_step;
      rate_n = cfg_rate;
`ifdef PULSE_SWEEP_LOOP_EN
      loop_n = cfg_loop;
`endif
    end
    if (stop) begin
      state_n = IDLE;
      presc_n = '0;
    end else if (start && (state == IDLE || state == HOLD)) begin
      // min_n already reflects a config word accepted this same cycle
      state_n = UP;
      pw_n    = min_n;
      presc_n = '0;
    end else if (sample_tick && (state == UP || state == DOWN)) begin
      if (presc == rate_q) begin
        presc_n = '0;
        if (state == UP) begin
          if (up_sum >= {1'b0, max_q}) begin
            pw_n = max_q;
            if (loop_eff) state_n = DOWN;
            else begin
              state_n = HOLD;
              done_n  = 1'b1;
            end
          end else begin
            pw_n = up_sum[W-1:0];
          end
        end else begin
          if (dn_diff[W] || dn_diff[W-1:0] <= min_q) begin
            pw_n    = min_q;
            state_n = UP;
          end else begin
            pw_n = dn_diff[W-1:0];
          end
        end
      end else begin
        presc_n = presc + 1'b1;
      end
    end
    busy_n  = (state_n == UP) || (state_n == DOWN);
    ready_n = (state_n == IDLE) || (state_n == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pulse_width <= {1'b1, {(W-1){1'b0}}};
      presc       <= '0;
      min_q       <= '0;
      max_q       <= '1;
      step_q      <= {{(W-1){1'b0}}, 1'b1};
      rate_q      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_ready   <= 1'b1;
`ifdef PULSE_SWEEP_LOOP_EN
      loop_q      <= 1'b1;
`endif
    end else begin
      state       <= state_n;
      pulse_width <= pw_n;
      presc       <= presc_n;
      min_q       <= min_n;
      max_q       <= max_n;
      step_q      <= step_n;
      rate_q      <= rate_n;
      busy        <= busy_n;
      done        <= done_n;
      cfg_ready   <= ready_n;
`ifdef PULSE_SWEEP_LOOP_EN
      loop_q      <= loop_n;
`endif
    end
  end
endmodule

// File: tb/tb_pulse_width_sweeper.sv
// Bench for pulse_width_sweeper: table vectors, corner sequences and random traffic vs. a waveform model.
module tb_pulse_width_sweeper;
  logic        clk = 1'b0, rst = 1'b1;
  logic        sample_tick = 1'b0, cfg_valid = 1'b0, cfg_loop = 1'b0, start = 1'b0, stop = 1'b0;
  logic        cfg_ready, busy, done;
  logic [11:0] cfg_min = '0, cfg_max = '0, cfg_step = '0, pulse_width;
  logic [15:0] cfg_rate = '0;

  pulse_width_sweeper #(.PULSEWIDTH_BITS(12), .RATE_BITS(16)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_min(cfg_min), .cfg_max(cfg_max), .cfg_step(cfg_step), .cfg_rate(cfg_rate), .cfg_loop(cfg_loop),
    .start(start), .stop(stop), .pulse_width(pulse_width), .busy(busy), .done(done));

  always #5 clk = ~clk;

  int n_total = 0, n_bad = 0;

  // Model: the sweep is a waveform indexed by step number k = ticks_since_start / (rate+1).
  int m_pw, m_min, m_max, m_step, m_rate, m_total;
  bit m_loop, m_run, m_done, done_seen;
  int wave[$];

  function automatic bit loop_honoured(bit l);
`ifdef PULSE_SWEEP_LOOP_EN
    return l;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int wave_at(int k);
    int v;
    if (loop_honoured(m_loop)) return wave[(k - 1) % wave.size()];
    v = m_min + k * m_step;
    return (v > m_max) ? m_max : v;
  endfunction

  task automatic build_wave();
    int v;
    wave.delete();
    v = m_min;
    do begin v = (v + m_step > m_max) ? m_max : v + m_step; wave.push_back(v); end while (v != m_max);
    do begin v = (v - m_step < m_min) ? m_min : v - m_step; wave.push_back(v); end while (v != m_min);
  endtask

  task automatic model_reset();
    m_pw = 'h800; m_min = 0; m_max = 'hFFF; m_step = 1; m_rate = 0; m_loop = 1;
    m_run = 0; m_done = 0; m_total = 0;
  endtask

  task automatic model_edge();
    m_done = 0;
    if (cfg_valid && !m_run) begin
      m_min  = cfg_min;
      m_max  = (cfg_min > cfg_max) ? int'(cfg_min) : int'(cfg_max);
      m_step = (cfg_step == 0) ? 1 : int'(cfg_step);
      m_rate = cfg_rate;
      m_loop = cfg_loop;
    end
    if (stop) m_run = 0;
    else if (start && !m_run) begin
      m_run = 1; m_total = 0; m_pw = m_min;
      if (loop_honoured(m_loop)) build_wave();
    end else if (m_run && sample_tick) begin
      m_total++;
      if (m_total % (m_rate + 1) == 0) begin
        m_pw = wave_at(m_total / (m_rate + 1));
        if (!loop_honoured(m_loop) && m_pw == m_max) begin m_run = 0; m_done = 1; end
      end
    end
  endtask

  task automatic check(string name, int act, int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(bit tk, bit st, bit sp, bit cv);
    sample_tick = tk; start = st; stop = sp; cfg_valid = cv;
    @(posedge clk);
    model_edge();
    #1;
    check("pulse_width", int'(pulse_width), m_pw);
    check("busy", int'(busy), int'(m_run));
    check("done", int'(done), int'(m_done));
    check("cfg_ready", int'(cfg_ready), int'(!m_run));
    if (done) done_seen = 1;
    sample_tick = 0; start = 0; stop = 0; cfg_valid = 0;
  endtask

  task automatic set_cfg(int mn, int mx, int st, int rt, bit lp);
    cfg_min = 12'(mn); cfg_max = 12'(mx); cfg_step = 12'(st); cfg_rate = 16'(rt); cfg_loop = lp;
  endtask

  typedef struct {
    int mn, mx, st, rt; bit lp; int ticks;
    int exp_pw; bit exp_busy; bit exp_done;
  } vec_t;
  vec_t vecs[6];

  initial begin
    vecs[0] = '{'h100, 'h140, 'h20, 0, 0, 3, 'h140, 0, 1};  // saturate at max, one-shot
    vecs[1] = '{'hFF0, 'hFFF, 'h100, 0, 0, 1, 'hFFF, 0, 1}; // no wrap at top of range
    vecs[2] = '{'h10, 'h20, 0, 0, 0, 5, 'h15, 1, 0};        // step 0 stored as 1
    vecs[3] = '{'h50, 'h20, 8, 0, 0, 1, 'h50, 0, 1};        // min > max collapses to min
    vecs[4] = '{'h0, 'h100, 'h10, 3, 0, 8, 'h20, 1, 0};     // step every 4th tick
`ifdef PULSE_SWEEP_LOOP_EN
    vecs[5] = '{'h10, 'h30, 'h10, 1, 1, 10, 'h20, 1, 0};    // triangle 20,30,20,10,20
`else
    vecs[5] = '{'h10, 'h30, 'h10, 1, 1, 10, 'h30, 0, 1};    // loop ignored: one-shot
`endif

    model_reset();
    #12;
    check("reset pulse_width", int'(pulse_width), 'h800);
    check("reset busy", int'(busy), 0);
    check("reset cfg_ready", int'(cfg_ready), 1);
    check("reset done", int'(done), 0);
    @(negedge clk); rst = 0;

    foreach (vecs[i]) begin
      cycle(0, 0, 1, 0);
      set_cfg(vecs[i].mn, vecs[i].mx, vecs[i].st, vecs[i].rt, vecs[i].lp);
      done_seen = 0;
      cycle(0, 1, 0, 1);  // config and start together
      for (int t = 0; t < vecs[i].ticks; t++) begin cycle(1, 0, 0, 0); cycle(0, 0, 0, 0); end
      check($sformatf("vec%0d pw", i), int'(pulse_width), vecs[i].exp_pw);
      check($sformatf("vec%0d busy", i), int'(busy), int'(vecs[i].exp_busy));
      check($sformatf("vec%0d done_seen", i), int'(done_seen), int'(vecs[i].exp_done));
    end

    // stop+start together mid-UP: idle, value kept
    cycle(0, 0, 1, 0);
    set_cfg('h200, 'h400, 'h40, 0, 0);
    cycle(0, 1, 0, 1);
    cycle(1, 0, 0, 0); cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 0);
    check("stop+start pw", int'(pulse_width), 'h280);
    check("stop+start busy", int'(busy), 0);

    // config offered during UP is refused
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    set_cfg('h700, 'h800, 'h1, 5, 0);
    cycle(0, 0, 0, 1);
    check("cfg during UP ready", int'(cfg_ready), 0);
    cycle(0, 0, 1, 0); cycle(0, 1, 0, 0);
    check("old min kept", int'(pulse_width), 'h200);
    cycle(1, 0, 0, 0);
    check("old step kept", int'(pulse_width), 'h240);

    // asynchronous reset mid-sweep
    #2 rst = 1;
    #1;
    check("async rst pw", int'(pulse_width), 'h800);
    check("async rst busy", int'(busy), 0);
    check("async rst ready", int'(cfg_ready), 1);
    @(negedge clk); rst = 0; model_reset();
    cycle(0, 0, 0, 0);

    // random traffic
    for (int r = 0; r < 30; r++) begin
      set_cfg($urandom_range(0, 4095), $urandom_range(0, 4095),
              ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(16, 4095), $urandom_range(0, 3), 1'($urandom));
      cycle(0, 0, 1, 0);
      cycle(0, 1, 0, 1);
      for (int c = 0; c < 40; c++) begin
        if ($urandom_range(0, 9) == 0)
          set_cfg($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095),
                  $urandom_range(0, 2), 1'($urandom));
        cycle(1'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
              $urandom_range(0, 9) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/pulse_width_sweeper.md
# pulse_width_sweeper

Sequencer that drives the `pulse_width` input of a pulse tone generator, sweeping it between programmable bounds at a programmable rate to produce PWM timbre movement. It sits beside the voice's phase accumulator and advances only on the global sample strobe. Configuration is loaded through a valid/ready handshake. A start/stop pair controls the sweep.

## Interface
- `PULSEWIDTH_BITS`, 12, width of pulse width values.
- `RATE_BITS`, 16, width of the sample-tick prescaler.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `sample_tick`  in  1  one-cycle strobe at the sample rate.
- `cfg_valid`  in  1  config word present.
- `cfg_ready`  out  1  sweeper can accept config.
- `cfg_min`  in  PULSEWIDTH_BITS  lower sweep bound.
- `cfg_max`  in  PULSEWIDTH_BITS  upper sweep bound.
- `cfg_step`  in  PULSEWIDTH_BITS  increment per step.
- `cfg_rate`  in  RATE_BITS  sample ticks per step, minus one.
- `cfg_loop`  in  1  1 = triangle loop, 0 = one-shot.
- `start`  in  1  begin sweep.
- `stop`  in  1  abort sweep.
- `pulse_width`  out  PULSEWIDTH_BITS  registered value to the tone generator.
- `busy`  out  1  high in UP or DOWN.
- `done`  out  1  one-cycle pulse when a one-shot reaches max.

## Operation
- States: IDLE, UP, DOWN, HOLD.
- Reset values:
  - state IDLE; `pulse_width` = 2^(PULSEWIDTH_BITS-1), a square wave.
  - `busy`=0, `done`=0, `cfg_ready`=1, prescaler=0.
  - Config registers: min=0, max=all-ones, step=1, rate=0, loop=1.
- Config handshake:
  - `cfg_ready` = 1 in IDLE or HOLD, otherwise 0.
  - A transfer occurs on a cycle with `cfg_valid && cfg_ready`. All five fields are captured.
  - `cfg_valid` while not ready is held off; nothing is captured.
- Config sanitising at capture:
  - `cfg_step`=0 is stored as 1.
  - If `cfg_min > cfg_max`, max is stored equal to min.
- `start` in IDLE or HOLD:
  - `pulse_width` ← min, prescaler ← 0, state ← UP.
  - `start` in UP or DOWN is ignored.
- `stop` in any state:
  - State ← IDLE; `pulse_width` retains its current value; prescaler cleared.
  - `stop` wins over a simultaneous `start`.
- A config transfer and `start` in the same cycle: `start` uses the newly captured values.
- Prescaler: on each `sample_tick` in UP/DOWN it increments. When it equals rate, it clears and a step occurs. rate=0 means a step every tick.
- UP step:
  - `pulse_width` ← min(pw+step, max), computed in PULSEWIDTH_BITS+1 bits with no wrap.
  - If the result equals max: with loop → DOWN; without loop → HOLD with `done`=1 for one cycle.
- DOWN step:
  - `pulse_width` ← max(pw−step, min), computed with a borrow check and no wrap.
  - If the result equals min → UP.
- min == max: the first UP step reaches max immediately, then the loop/one-shot rules above apply.
- HOLD keeps `pulse_width` at max until `start`, `stop` or reset.

## Timing
- All outputs are registered.
- `pulse_width` changes in the cycle after the qualifying `sample_tick`.
- After `start`, `pulse_width`=min and `busy`=1 on the next cycle.
- Step period = (rate+1) sample ticks.
- `done` asserts in the same cycle that `pulse_width` first shows max and HOLD is entered.
- `cfg_ready` deasserts in the cycle after `start` is accepted.
- Asynchronous `rst` mid-sweep immediately forces all reset values.

## Configuration
- `PULSE_SWEEP_LOOP_EN`
  - Defined: `cfg_loop` is honoured and the DOWN state exists.
  - Undefined: `cfg_loop` is ignored and treated as 0. Every sweep is one-shot, DOWN is never entered, and `done` always fires at max.

## Test plan
- Reset → `pulse_width`=0x800, `busy`=0, `cfg_ready`=1, `done`=0.
- Config min=0x100, max=0x140, step=0x20, rate=0, loop=0; `start`; 3 ticks.
  - Expect `pulse_width` 0x100 → 0x120 → 0x140 (saturated).
  - Expect `done` pulse, HOLD, `cfg_ready`=1.
- Loop mode: min=0x10, max=0x30, step=0x10, rate=1.
  - Expect a step every 2nd tick: 0x10, 0x20, 0x30, 0x20, 0x10, 0x20.
- Saturation: min=0xFF0, max=0xFFF, step=0x100.
  - Expect the first step to give 0xFFF, with no wrap to 0x0F0.
- `stop` and `start` in the same cycle mid-UP → IDLE, `pulse_width` unchanged, `busy`=0.
- Config with `cfg_valid` during UP → `cfg_ready`=0 and registers unchanged. Assert `rst` mid-sweep → immediate reset values.
